// File: rtl/bellek_yanitlayici_if.sv
// Request/response bus between the multicycle core and the wait-state memory responder.
// The master drives requests. The slave (the responder) accepts them and returns one-cycle responses.
interface bellek_yanitlayici_if #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32
);
  logic                  istek_gecerli;
  logic                  istek_hazir;
  logic                  istek_yaz;
  logic [ADRES_BIT-1:0]  adres;
  logic [VERI_BIT-1:0]   yaz_veri;
  logic [VERI_BIT/8-1:0] yaz_maske;
  logic                  yanit_gecerli;
  logic [VERI_BIT-1:0]   oku_veri;
  logic                  hata;

  modport master (
    output istek_gecerli, istek_yaz, adres, yaz_veri, yaz_maske,
    input  istek_hazir, yanit_gecerli, oku_veri, hata
  );

  modport slave (
    input  istek_gecerli, istek_yaz, adres, yaz_veri, yaz_maske,
    output istek_hazir, yanit_gecerli, oku_veri, hata
  );
endinterface

// File: rtl/bellek_yanitlayici.sv
// Memory-side responder with programmable wait states. It serves one request at a time.
// Each request is held for GECIKME cycles, then goes to the word array `bellek`, then a one-cycle response is returned.
module bellek_yanitlayici #(
  parameter int                   ADRES_BIT    = 32,
  parameter int                   VERI_BIT     = 32,
  parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = 32'h8000_0000,
  parameter int                   SATIR_SAYISI = 1024,
  parameter int                   GECIKME      = 2
) (
  input  logic               clk,
  input  logic               rst,
  bellek_yanitlayici_if.slave bus
);

  localparam int          SERIT     = VERI_BIT / 8;
  localparam int          SATIR_BIT = (SATIR_SAYISI > 1) ? $clog2(SATIR_SAYISI) : 1;
  localparam logic [7:0]  GECIKME_8 = 8'(GECIKME);

  typedef enum logic [1:0] {
    BOSTA,
    BEKLE,
    YANIT
  } durum_t;

  durum_t                durum, durum_sonraki;
  logic [7:0]            sayac, sayac_sonraki;

  logic                  istek_yaz_r;
  logic [ADRES_BIT-1:0]  adres_r;
  logic [VERI_BIT-1:0]   yaz_veri_r;
  logic [SERIT-1:0]      yaz_maske_r;

  logic                  yanit_r, yanit_sonraki;
  logic                  hata_r, hata_sonraki;
  logic [VERI_BIT-1:0]   oku_r, oku_sonraki;

  logic                  yakala;
  logic                  yaz_et;

  logic [VERI_BIT-1:0]   bellek [SATIR_SAYISI];

  // The address is decoded from the latched request, so the access uses the address that was accepted.
  logic [ADRES_BIT-1:0]  ofset;
  logic [ADRES_BIT-1:0]  satir;
  logic [SATIR_BIT-1:0]  satir_idx;
  logic                  adres_hatali;

  assign ofset        = adres_r - BELLEK_ADRES;
  assign satir        = ofset >> 2;
  assign satir_idx    = satir[SATIR_BIT-1:0];
  assign adres_hatali = (adres_r < BELLEK_ADRES)
                     || (satir >= ADRES_BIT'(SATIR_SAYISI))
                     || (adres_r[1:0] != 2'b00);

  assign bus.istek_hazir   = (durum == BOSTA) && !rst;
  assign bus.yanit_gecerli = yanit_r;
  assign bus.hata          = hata_r;
  assign bus.oku_veri      = oku_r;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    durum_sonraki = durum;
    sayac_sonraki = sayac;
    yanit_sonraki = yanit_r;
    hata_sonraki  = hata_r;
    oku_sonraki   = oku_r;
    yakala        = 1'b0;
    yaz_et        = 1'b0;

    unique case (durum)
      BOSTA: begin
        if (bus.istek_gecerli) begin
          yakala        = 1'b1;
          sayac_sonraki = GECIKME_8;
          durum_sonraki = BEKLE;
        end
      end

      BEKLE: begin
        if (sayac == 8'd0) begin
          durum_sonraki = YANIT;
          yanit_sonraki = 1'b1;
          if (adres_hatali) begin
            hata_sonraki = 1'b1;
            oku_sonraki  = '0;
          end else if (istek_yaz_r) begin
            yaz_et       = 1'b1;
            hata_sonraki = 1'b0;
            oku_sonraki  = '0;
          end else begin
            hata_sonraki = 1'b0;
            oku_sonraki  = bellek[satir_idx];
          end
        end else begin
          sayac_sonraki = sayac - 8'd1;
        end
      end

      YANIT: begin
        yanit_sonraki = 1'b0;
        hata_sonraki  = 1'b0;
        oku_sonraki   = '0;
        durum_sonraki = BOSTA;
      end

      default: durum_sonraki = BOSTA;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values and ordering inside the block does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      durum   <= BOSTA;
      sayac   <= 8'd0;
      yanit_r <= 1'b0;
      hata_r  <= 1'b0;
      oku_r   <= '0;
    end else begin
      durum   <= durum_sonraki;
      sayac   <= sayac_sonraki;
      yanit_r <= yanit_sonraki;
      hata_r  <= hata_sonraki;
      oku_r   <= oku_sonraki;
    end
  end

  // Request holding registers only matter after acceptance, so they load on capture and need no reset.
  always_ff @(posedge clk) begin
    if (yakala && !rst) begin
      istek_yaz_r <= bus.istek_yaz;
      adres_r     <= bus.adres;
      yaz_veri_r  <= bus.yaz_veri;
      yaz_maske_r <= bus.yaz_maske;
    end
  end

  // NOTE: the array is deliberately left out of reset. A reset must not wipe backdoor-loaded contents, and a resettable array could not map onto RAM.
  always_ff @(posedge clk) begin
    if (yaz_et && !rst) begin
      for (int i = 0; i < SERIT; i++) begin
        if (yaz_maske_r[i])
          bellek[satir_idx][8*i +: 8] <= yaz_veri_r[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Directed bench for bellek_yanitlayici. It drives one instance with GECIKME=2 and one with GECIKME=0.
// Expected responses are queued when a request is driven and compared when the response appears.
module tb_bellek_yanitlayici;

  typedef struct {
    logic        hata;
    logic [31:0] veri;
  } beklenen_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned kenar = 0;
  int          assert_sayisi = 0;
  int          hata_sayisi = 0;
  beklenen_t   sb[$];

  bellek_yanitlayici_if a ();
  bellek_yanitlayici_if a0 ();

  bellek_yanitlayici #(.GECIKME(2)) dut  (.clk(clk), .rst(rst), .bus(a));
  bellek_yanitlayici #(.GECIKME(0)) dut0 (.clk(clk), .rst(rst), .bus(a0));

  always #5 clk = ~clk;

  always @(posedge clk) kenar <= kenar + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    assert_sayisi++;
    assert (gozlenen === beklenen) else begin
      hata_sayisi++;
      $error("FAIL %s: observed=%h expected=%h", tag, gozlenen, beklenen);
    end
  endtask

  // Drives one request into the GECIKME=2 instance. It waits for the response and checks the timing and payload.
  task automatic istek(input string tag, input logic yaz, input logic [31:0] adr,
                       input logic [31:0] veri, input logic [3:0] maske,
                       input logic b_hata, input logic [31:0] b_veri);
    int unsigned k;
    int          sure;
    beklenen_t   b;
    sb.push_back('{b_hata, b_veri});
    a.istek_gecerli = 1'b1;
    a.istek_yaz     = yaz;
    a.adres         = adr;
    a.yaz_veri      = veri;
    a.yaz_maske     = maske;
    sure = 0;
    while (a.istek_hazir !== 1'b1 && sure < 20) begin
      @(negedge clk);
      sure++;
    end
    check({tag, "_kabul"}, 32'(sure < 20), 32'd1);
    k = kenar + 1;
    @(negedge clk);
    a.istek_gecerli = 1'b0;
    sure = 0;
    while (a.yanit_gecerli !== 1'b1 && sure < 20) begin
      check({tag, "_hazir_dusuk"}, 32'(a.istek_hazir), 32'd0);
      @(negedge clk);
      sure++;
    end
    if (sure >= 20) begin
      check({tag, "_yanit_zaman_asimi"}, 32'd0, 32'd1);
      b = sb.pop_front();
      return;
    end
    check({tag, "_gecikme"}, kenar - k, 32'd3);
    b = sb.pop_front();
    check({tag, "_hata"}, 32'(a.hata), 32'(b.hata));
    check({tag, "_veri"}, a.oku_veri, b.veri);
    check({tag, "_hazir_yanitta"}, 32'(a.istek_hazir), 32'd0);
    @(negedge clk);
    check({tag, "_tek_cevrim"}, 32'(a.yanit_gecerli), 32'd0);
    check({tag, "_hazir_geri"}, 32'(a.istek_hazir), 32'd1);
  endtask

  initial begin
    int unsigned k0;
    int          yanit_say;
    int unsigned ofsetler[4];
    beklenen_t   b;

    ofsetler = '{32'd1, 32'd4, 32'd7, 32'd10};

    rst = 1'b1;
    a.istek_gecerli = 1'b0;  a.istek_yaz = 1'b0;  a.adres = '0;  a.yaz_veri = '0;  a.yaz_maske = '0;
    a0.istek_gecerli = 1'b0; a0.istek_yaz = 1'b0; a0.adres = '0; a0.yaz_veri = '0; a0.yaz_maske = '0;

    dut.bellek[0]  = 32'haae00893;
    dut.bellek[2]  = 32'h0BAD_F00D;
    dut.bellek[3]  = 32'h3333_3333;
    dut0.bellek[0] = 32'haae00893;

    repeat (2) @(negedge clk);
    check("reset_hazir", 32'(a.istek_hazir), 32'd0);
    check("reset_yanit", 32'(a.yanit_gecerli), 32'd0);
    check("reset_hata", 32'(a.hata), 32'd0);
    check("reset_veri", a.oku_veri, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_sonrasi_hazir", 32'(a.istek_hazir), 32'd1);

    istek("oku0", 1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b0, 32'haae00893);

    istek("yaz4_tam", 1'b1, 32'h8000_0004, 32'h1234_5678, 4'b1111, 1'b0, 32'd0);
    istek("yaz4_maske", 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'd0);
    istek("oku4", 1'b0, 32'h8000_0004, 32'd0, 4'h0, 1'b0, 32'h12BB_56DD);

    istek("alt_sinir", 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 1'b1, 32'd0);
    istek("hizasiz", 1'b0, 32'h8000_0002, 32'd0, 4'h0, 1'b1, 32'd0);
    istek("ust_sinir", 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'd0);
    check("satir0_korunur", dut.bellek[0], 32'haae00893);

    istek("maske0", 1'b1, 32'h8000_000C, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'd0);
    check("satir3_korunur", dut.bellek[3], 32'h3333_3333);

    // Reset pulsed while the write is waiting in BEKLE.
    a.istek_gecerli = 1'b1;
    a.istek_yaz     = 1'b1;
    a.adres         = 32'h8000_0008;
    a.yaz_veri      = 32'hDEAD_BEEF;
    a.yaz_maske     = 4'b1111;
    @(negedge clk);
    a.istek_gecerli = 1'b0;
    check("rst_oncesi_bekle", 32'(a.istek_hazir), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_hazir_dusuk1", 32'(a.istek_hazir), 32'd0);
    @(negedge clk);
    check("rst_hazir_dusuk2", 32'(a.istek_hazir), 32'd0);
    check("rst_yanit_yok", 32'(a.yanit_gecerli), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sonrasi_hazir", 32'(a.istek_hazir), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("rst_sonrasi_yanit_yok", 32'(a.yanit_gecerli), 32'd0);
      @(negedge clk);
    end
    check("satir2_korunur", dut.bellek[2], 32'h0BAD_F00D);

    // GECIKME=0 with istek_gecerli held high for 12 cycles gives one response every 3 cycles.
    for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 32'haae00893});
    a0.istek_gecerli = 1'b1;
    a0.istek_yaz     = 1'b0;
    a0.adres         = 32'h8000_0000;
    check("g0_hazir_basta", 32'(a0.istek_hazir), 32'd1);
    k0 = kenar + 1;
    yanit_say = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a0.yanit_gecerli === 1'b1) begin
        check("g0_zaman", kenar - k0, (yanit_say < 4) ? ofsetler[yanit_say] : 32'hFFFF_FFFF);
        if (sb.size() > 0) begin
          b = sb.pop_front();
          check("g0_veri", a0.oku_veri, b.veri);
          check("g0_hata", 32'(a0.hata), 32'(b.hata));
        end
        yanit_say++;
      end
    end
    a0.istek_gecerli = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a0.yanit_gecerli === 1'b1) yanit_say++;
    end
    check("g0_yanit_sayisi", 32'(yanit_say), 32'd4);
    check("sb_bos", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_sayisi, hata_sayisi);
    $finish;
  end

endmodule

// File: doc/bellek_yanitlayici.md
Name: bellek_yanitlayici

Overview:
- Memory-side responder for the multicycle core's data/instruction bus: accepts one read or write request at a time through a valid/ready handshake.
- Holds the request for a programmable number of wait cycles, then performs the access on an internal word array and returns a one-cycle response.
- Replaces the zero-latency main memory when the core's bus is being exercised under wait states.
- Uses the same address window (base 32'h8000_0000, word-indexed) so backdoor loading of the `bellek` array works unchanged.

Parameters:
- BELLEK_ADRES, 32'h8000_0000, base byte address of row 0.
- ADRES_BIT, 32, address width.
- VERI_BIT, 32, data width; byte lanes = VERI_BIT/8.
- SATIR_SAYISI, 1024, number of words in array `bellek`.
- GECIKME, 2, wait cycles between acceptance and access (0 allowed, max 255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- istek_gecerli  input  1  request valid.
- istek_hazir  output  1  responder can accept a request (high only in BOSTA).
- istek_yaz  input  1  1 = write, 0 = read.
- adres  input  ADRES_BIT  byte address.
- yaz_veri  input  VERI_BIT  write data.
- yaz_maske  input  VERI_BIT/8  byte-lane write enables; bit i writes byte i.
- yanit_gecerli  output  1  response valid; high for exactly one cycle.
- oku_veri  output  VERI_BIT  read data; valid while yanit_gecerli is high.
- hata  output  1  request rejected (out of range or misaligned); valid with yanit_gecerli.

Behaviour:
- Reset (rst high at an edge):
  - State goes to BOSTA.
  - yanit_gecerli=0, hata=0, oku_veri=0, wait counter=0.
  - istek_hazir is held 0 while rst is high.
  - Array contents are not cleared.
- State BOSTA:
  - istek_hazir=1.
  - At an edge with istek_gecerli=1, latch adres, yaz_veri, yaz_maske and istek_yaz.
  - Load counter with GECIKME and go to BEKLE.
  - Inputs are ignored in every other state.
- State BEKLE:
  - istek_hazir=0.
  - At each edge: if counter==0, perform the access, register the response and go to YANIT; otherwise decrement the counter.
- Access:
  - Row = (adres - BELLEK_ADRES) >> 2.
  - Error condition: adres < BELLEK_ADRES, row >= SATIR_SAYISI, or adres[1:0] != 0. Result: hata=1, oku_veri=0, no write.
  - Read: oku_veri = bellek[row], hata=0.
  - Write: update only bytes with yaz_maske[i]=1; oku_veri=0, hata=0. A write with mask 0 still responds and leaves the array unchanged.
- State YANIT:
  - yanit_gecerli=1 and istek_hazir=0.
  - At the next edge clear yanit_gecerli, hata and oku_veri, and go to BOSTA.
- Latency:
  - Request accepted at edge k.
  - Response visible from edge k+GECIKME+1 for exactly one cycle.
  - Next acceptance possible at edge k+GECIKME+3.
  - Back-to-back throughput is one request per GECIKME+3 cycles.
- Reset mid-operation:
  - rst in BEKLE abandons the request; no write occurs.
  - rst in YANIT drops yanit_gecerli at that edge; a write already committed stays.
- istek_gecerli held high across a response: a new request is accepted only at an edge where istek_hazir=1. There is no double acceptance.
- Counter width: 8 bits. GECIKME=0 gives a single BEKLE cycle.

Test Plan:
- Backdoor `bellek[0]=32'haae00893`, GECIKME=2, read 32'h8000_0000 accepted at edge k -> yanit_gecerli high only after edge k+3, oku_veri=32'haae00893, hata=0; istek_hazir low for edges k+1..k+3 and high again after edge k+4.
- Write 32'h1234_5678 mask 4'b1111 to 32'h8000_0004, then write 32'hAABB_CCDD mask 4'b0101 to the same address, then read it back -> oku_veri=32'h12BB_56DD.
- Read 32'h7FFF_FFFC, read 32'h8000_0002, and write 32'h8000_1000 (SATIR_SAYISI=1024) -> each returns hata=1 and oku_veri=0; array row 0 is unchanged for the write.
- GECIKME=0, istek_gecerli held high for 12 cycles with reads of 32'h8000_0000 -> exactly 4 responses, at edges k+1, k+4, k+7, k+10.
- Write 32'hDEAD_BEEF to 32'h8000_0008 with rst pulsed during BEKLE -> no response, `bellek[2]` unchanged, istek_hazir=0 during reset and 1 in the cycle after rst falls.
- Write with mask 4'b0000 to 32'h8000_000c -> yanit_gecerli=1, hata=0, `bellek[3]` unchanged.
